// File: rtl/fwpic2_pkg.sv
// Shared constants and helpers for the fwpic2 Wishbone interrupt controller.
// Register offsets are word indices on rt_adr[4:2].
package fwpic2_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_PENDING  = 3'd1;
    localparam logic [2:0] REG_ENABLE   = 3'd2;
    localparam logic [2:0] REG_MODE     = 3'd3;
    localparam logic [2:0] REG_POLARITY = 3'd4;
    localparam logic [2:0] REG_CLAIM    = 3'd5;
    localparam logic [2:0] REG_CTRL     = 3'd6;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    localparam int CLAIM_VALID_BIT = 31;

    typedef enum logic {
        ACK_IDLE,
        ACK_BUSY
    } ack_state_e;

    // Merge a write into a 32-bit register image, one byte lane per rt_sel bit.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_val & ~mask) | (wdata & mask);
    endfunction

    function automatic logic [31:0] lane_bits(input logic [31:0] wdata,
                                              input logic [3:0]  sel);
        return wdata & {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/fwpic2_if.sv
// Wishbone classic slave bus between the peripheral interconnect and fwpic2_wb.
interface fwpic2_if;
    logic [31:0] rt_adr;
    logic [31:0] rt_dat_w;
    logic [31:0] rt_dat_r;
    logic        rt_cyc;
    logic        rt_stb;
    logic        rt_we;
    logic [3:0]  rt_sel;
    logic        rt_ack;

    modport master (output rt_adr, rt_dat_w, rt_cyc, rt_stb, rt_we, rt_sel,
                    input  rt_dat_r, rt_ack);
    modport slave  (input  rt_adr, rt_dat_w, rt_cyc, rt_stb, rt_we, rt_sel,
                    output rt_dat_r, rt_ack);
endinterface

// File: rtl/fwpic2_chan.sv
// One interrupt channel: synchroniser, polarity correction, rising-edge detect
// and the pending flop, where a new edge always beats a simultaneous clear.
module fwpic2_chan
    import fwpic2_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic irq_i,
    input  logic polarity_i,
    input  logic mode_i,
    input  logic clear_i,
    output logic pending_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pending_q, pending_d;
    logic                   level;
    logic                   rise;

    // NOTE: give every always_comb output a default first; a path that leaves one unassigned infers a latch.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = irq_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

        level  = sync_q[SYNC_STAGES-1] ^ polarity_i;
        rise   = level & ~prev_q;
        prev_d = level;

        if (mode_i == MODE_LEVEL) pending_d = level;
        else                      pending_d = rise | (pending_q & ~clear_i);
    end

    // NOTE: sequential state is updated only with <=, so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

    // A mode of MODE_EDGE keeps the bit until cleared; the level path ignores clear_i.
    logic unused_edge_const;
    assign unused_edge_const = (MODE_EDGE != MODE_LEVEL);

endmodule

// File: rtl/fwpic2_wb.sv
// fwpic2 top: Wishbone ack FSM, register file, lowest-index priority encoder
// and the registered interrupt request to the core.
module fwpic2_wb
    import fwpic2_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    fwpic2_if.slave          wb,
    output logic             int_o,
    output logic [7:0]       int_id,
    input  logic [N_IRQ-1:0] irq
);

    ack_state_e        state_q, state_d;
    logic [N_IRQ-1:0]  enable_q, enable_d;
    logic [N_IRQ-1:0]  mode_q, mode_d;
    logic [N_IRQ-1:0]  polarity_q, polarity_d;
    logic              ctrl_q, ctrl_d;
    logic [31:0]       dat_r_q, dat_r_d;
    logic              int_q, int_d;
    logic [7:0]        id_q, id_d;

    logic [N_IRQ-1:0]  pending;
    logic [N_IRQ-1:0]  status;
    logic [N_IRQ-1:0]  clear;
    logic              active;
    logic              fire;
    logic [7:0]        low_id;
    logic [2:0]        offset;
    logic [31:0]       rdata;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_chan
        fwpic2_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
            .clock      (clock),
            .reset      (reset),
            .irq_i      (irq[g]),
            .polarity_i (polarity_q[g]),
            .mode_i     (mode_q[g]),
            .clear_i    (clear[g]),
            .pending_o  (pending[g])
        );
    end

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        status = pending & enable_q;
        active = (status != '0) && ctrl_q;
        low_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (status[i]) low_id = 8'(i);
        end
    end

    always_comb begin
        offset = wb.rt_adr[4:2];
        case (offset)
            REG_STATUS:   rdata = 32'(status);
            REG_PENDING:  rdata = 32'(pending);
            REG_ENABLE:   rdata = 32'(enable_q);
            REG_MODE:     rdata = 32'(mode_q);
            REG_POLARITY: rdata = 32'(polarity_q);
            REG_CLAIM:    rdata = active ? ((32'd1 << CLAIM_VALID_BIT) | 32'(low_id)) : 32'd0;
            REG_CTRL:     rdata = {31'd0, ctrl_q};
            default:      rdata = 32'd0;
        endcase
    end

    // Everything a transfer does (write commit, read capture, claim retire)
    // happens on the edge that raises rt_ack.
    always_comb begin
        fire       = (state_q == ACK_IDLE) && wb.rt_cyc && wb.rt_stb;
        state_d    = fire ? ACK_BUSY : ACK_IDLE;
        enable_d   = enable_q;
        mode_d     = mode_q;
        polarity_d = polarity_q;
        ctrl_d     = ctrl_q;
        dat_r_d    = dat_r_q;
        clear      = '0;

        if (fire) begin
            dat_r_d = rdata;
            if (wb.rt_we) begin
                case (offset)
                    REG_PENDING:  clear      = N_IRQ'(lane_bits(wb.rt_dat_w, wb.rt_sel));
                    REG_ENABLE:   enable_d   = N_IRQ'(lane_merge(32'(enable_q), wb.rt_dat_w, wb.rt_sel));
                    REG_MODE:     mode_d     = N_IRQ'(lane_merge(32'(mode_q), wb.rt_dat_w, wb.rt_sel));
                    REG_POLARITY: polarity_d = N_IRQ'(lane_merge(32'(polarity_q), wb.rt_dat_w, wb.rt_sel));
                    REG_CTRL:     ctrl_d     = wb.rt_sel[0] ? wb.rt_dat_w[0] : ctrl_q;
                    default:      ;
                endcase
            end else if (offset == REG_CLAIM && active) begin
                for (int i = 0; i < N_IRQ; i++) begin
                    if (8'(i) == low_id) clear[i] = 1'b1;
                end
            end
        end

        int_d = active;
        id_d  = active ? low_id : 8'd0;
    end

    // NOTE: there is no memory array here; every register is a flop and all of them are reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ACK_IDLE;
            enable_q   <= '0;
            mode_q     <= '0;
            polarity_q <= '0;
            ctrl_q     <= 1'b0;
            dat_r_q    <= '0;
            int_q      <= 1'b0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            polarity_q <= polarity_d;
            ctrl_q     <= ctrl_d;
            dat_r_q    <= dat_r_d;
            int_q      <= int_d;
            id_q       <= id_d;
        end
    end

    assign wb.rt_ack   = (state_q == ACK_BUSY);
    assign wb.rt_dat_r = dat_r_q;
    assign int_o       = int_q;
    assign int_id      = id_q;

endmodule

// File: tb/tb_fwpic2_wb.sv
// Self-checking bench for fwpic2_wb: directed scenarios plus a random phase,
// with read data checked by a monitor against an expectation queue.
module tb_fwpic2_wb;

    localparam int N_IRQ = 8;
    localparam int SYNC  = 2;
    localparam logic [31:0] NMASK = (N_IRQ == 32) ? 32'hFFFF_FFFF : ((32'd1 << N_IRQ) - 32'd1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N_IRQ-1:0] irq   = '0;
    logic             int_o;
    logic [7:0]       int_id;

    fwpic2_if wb_bus ();

    fwpic2_wb #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC)) dut (
        .clock  (clock),
        .reset  (reset),
        .wb     (wb_bus),
        .int_o  (int_o),
        .int_id (int_id),
        .irq    (irq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    // Reference model: register contents and the settled polarity-corrected levels.
    logic [31:0] m_pend, m_en, m_mode, m_pol, m_s;
    logic        m_ctrl;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_pend = '0; m_en = '0; m_mode = '0; m_pol = '0; m_s = '0; m_ctrl = 1'b0;
    endfunction

    // Apply a new settled level vector: rising edges latch in edge channels,
    // level channels simply follow the level.
    function automatic void m_level(input logic [31:0] new_s);
        m_pend = m_pend | (new_s & ~m_s & m_mode);
        m_s    = new_s & NMASK;
        m_pend = ((m_pend & m_mode) | (m_s & ~m_mode)) & NMASK;
    endfunction

    function automatic bit m_active();
        return ((m_pend & m_en) != 0) && m_ctrl;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < N_IRQ; i++) if (m_pend[i] && m_en[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] sel);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (sel[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic logic [31:0] m_read(input int off);
        case (off)
            0: return m_pend & m_en;
            1: return m_pend;
            2: return m_en;
            3: return m_mode;
            4: return m_pol;
            5: return m_active() ? (32'h8000_0000 | 32'(m_lowest())) : 32'd0;
            6: return {31'd0, m_ctrl};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_claim();
        int id;
        if (m_active()) begin
            id = m_lowest();
            if (m_mode[id]) m_pend[id] = 1'b0;
        end
    endfunction

    function automatic void m_write(input int off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] mask;
        mask = lanes(sel) & NMASK;
        case (off)
            1: m_pend = m_pend & ~(d & mask & m_mode);
            2: m_en   = (m_en & ~mask) | (d & mask);
            3: begin m_mode = (m_mode & ~mask) | (d & mask); m_level(m_s); end
            4: begin m_pol = (m_pol & ~mask) | (d & mask); m_level(32'(irq) ^ m_pol); end
            6: if (sel[0]) m_ctrl = d[0];
            default: ;
        endcase
    endfunction

    task automatic bus(input int off, input bit we, input logic [31:0] wd,
                       input logic [3:0] sel, input string name);
        int lat;
        if (we) begin
            exp_q.push_back(32'd0); chk_q.push_back(1'b0);
        end else begin
            exp_q.push_back(m_read(off)); chk_q.push_back(1'b1);
            if (off == 5) m_claim();
        end
        name_q.push_back(name);
        @(negedge clock);
        wb_bus.rt_adr   = 32'(off) << 2;
        wb_bus.rt_dat_w = wd;
        wb_bus.rt_we    = we;
        wb_bus.rt_sel   = sel;
        wb_bus.rt_cyc   = 1'b1;
        wb_bus.rt_stb   = 1'b1;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (wb_bus.rt_ack !== 1'b1 && lat < 8);
        wb_bus.rt_cyc = 1'b0;
        wb_bus.rt_stb = 1'b0;
        wb_bus.rt_we  = 1'b0;
        check({name, "_ack_latency"}, 32'(lat), 32'd1);
        if (we) m_write(off, wd, sel);
        @(posedge clock); #1;
    endtask

    task automatic wr(input int off, input logic [31:0] wd, input logic [3:0] sel, input string name);
        bus(off, 1'b1, wd, sel, name);
    endtask

    task automatic rd(input int off, input string name);
        bus(off, 1'b0, 32'd0, 4'h0, name);
    endtask

    task automatic settle(input string name);
        repeat (SYNC + 3) @(posedge clock);
        #1;
        check({name, "_int_o"}, 32'(int_o), 32'(m_active()));
        check({name, "_int_id"}, 32'(int_id), m_active() ? 32'(m_lowest()) : 32'd0);
    endtask

    // Monitor: every acknowledged transfer consumes one queued expectation.
    initial begin
        logic [31:0] e;
        bit          c;
        string       n;
        forever begin
            @(negedge clock);
            if (wb_bus.rt_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack with data 0x%08h, required no ack", wb_bus.rt_dat_r);
                end else begin
                    e = exp_q.pop_front();
                    c = chk_q.pop_front();
                    n = name_q.pop_front();
                    if (c) check(n, wb_bus.rt_dat_r, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish within 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        wb_bus.rt_adr = '0; wb_bus.rt_dat_w = '0; wb_bus.rt_we = 1'b0;
        wb_bus.rt_sel = '0; wb_bus.rt_cyc = 1'b0; wb_bus.rt_stb = 1'b0;
        m_reset();

        // Reset and defaults.
        repeat (3) @(posedge clock);
        #1;
        check("reset_ack", 32'(wb_bus.rt_ack), 32'd0);
        check("reset_dat_r", wb_bus.rt_dat_r, 32'd0);
        check("reset_int_o", 32'(int_o), 32'd0);
        check("reset_int_id", 32'(int_id), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int off = 0; off < 8; off++) rd(off, $sformatf("default_off%0d", off));

        // A held strobe acknowledges every other cycle.
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(m_read(0)); chk_q.push_back(1'b1); name_q.push_back("held_read");
        end
        @(negedge clock);
        wb_bus.rt_adr = 32'd0; wb_bus.rt_we = 1'b0; wb_bus.rt_cyc = 1'b1; wb_bus.rt_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            check($sformatf("held_ack_cycle%0d", k), 32'(wb_bus.rt_ack), 32'((k % 2) == 0));
        end
        wb_bus.rt_cyc = 1'b0; wb_bus.rt_stb = 1'b0;
        @(posedge clock); #1;

        // Level channel with SYNC_STAGES+2 latency to int_o.
        wr(2, 32'h04, 4'hF, "level_en");
        wr(6, 32'h01, 4'hF, "level_ctrl");
        @(negedge clock);
        irq[2] = 1'b1;
        repeat (SYNC + 1) @(posedge clock);
        #1;
        check("level_int_o_early", 32'(int_o), 32'd0);
        @(posedge clock); #1;
        check("level_int_o", 32'(int_o), 32'd1);
        check("level_int_id", 32'(int_id), 32'd2);
        m_level(32'(irq) ^ m_pol);
        wr(1, 32'h04, 4'hF, "level_w1c");
        rd(1, "level_pending_after_w1c");
        @(negedge clock);
        irq[2] = 1'b0;
        m_level(32'(irq) ^ m_pol);
        settle("level_drop");

        // Edge channels and claim.
        wr(3, 32'h0A, 4'hF, "edge_mode");
        wr(2, 32'h0A, 4'hF, "edge_en");
        @(negedge clock);
        irq[1] = 1'b1; irq[3] = 1'b1;
        m_level(32'(irq) ^ m_pol);
        @(negedge clock);
        irq = '0;
        m_level(32'(irq) ^ m_pol);
        settle("edge_pulse");
        rd(5, "claim_first");
        settle("claim_first");
        rd(5, "claim_second");
        check("claim_second_int_o_fall", 32'(int_o), 32'd0);
        rd(5, "claim_empty");
        rd(1, "claim_pending_after");

        // Polarity and byte lanes.
        wr(4, 32'h01, 4'hF, "pol_write");
        settle("pol");
        rd(1, "pol_pending");
        wr(2, 32'hFFFF_FFFF, 4'b0001, "lane_en_full");
        rd(2, "lane_en_read");
        wr(2, 32'h0000_0000, 4'b1110, "lane_en_upper");
        rd(2, "lane_en_upper_read");
        settle("lane");

        // Global gate.
        wr(6, 32'h0, 4'hF, "gate_off");
        settle("gate_off");
        rd(0, "gate_status");
        wr(6, 32'h1, 4'hF, "gate_on");
        settle("gate_on");

        // Set-wins: rising edge lands on the W1C ack edge.
        wr(4, 32'h00, 4'hF, "race_pol");
        wr(3, 32'h01, 4'hF, "race_mode");
        @(negedge clock);
        irq[0] = 1'b1;
        m_level(32'(irq) ^ m_pol);
        @(negedge clock);
        irq[0] = 1'b0;
        m_level(32'(irq) ^ m_pol);
        settle("race_prep");
        @(negedge clock);
        irq[0] = 1'b1;
        @(negedge clock);
        wr(1, 32'h01, 4'hF, "race_w1c");
        m_level(32'(irq) ^ m_pol);
        rd(1, "race_pending");
        @(negedge clock);
        irq[0] = 1'b0;
        m_level(32'(irq) ^ m_pol);
        settle("race_drop");
        wr(1, 32'h01, 4'hF, "plain_w1c");
        rd(1, "plain_w1c_pending");

        // Reset during ACK.
        @(negedge clock);
        wb_bus.rt_adr = 32'd2 << 2; wb_bus.rt_dat_w = 32'h55; wb_bus.rt_sel = 4'hF;
        wb_bus.rt_we = 1'b1; wb_bus.rt_cyc = 1'b1; wb_bus.rt_stb = 1'b1;
        @(posedge clock); #1;
        check("midreset_ack_before", 32'(wb_bus.rt_ack), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_ack_dropped", 32'(wb_bus.rt_ack), 32'd0);
        wb_bus.rt_cyc = 1'b0; wb_bus.rt_stb = 1'b0; wb_bus.rt_we = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        rd(2, "midreset_enable");
        rd(6, "midreset_ctrl");
        rd(3, "midreset_mode");
        settle("midreset");

        // Random phase against the model.
        wr(6, 32'h1, 4'h1, "rand_ctrl");
        for (int it = 0; it < 80; it++) begin
            int op;
            int off;
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                @(negedge clock);
                irq = N_IRQ'($urandom);
                m_level(32'(irq) ^ m_pol);
            end else if (op == 1) begin
                off = int'($urandom_range(0, 7));
                wr(off, $urandom, 4'($urandom_range(0, 15)), $sformatf("rand_wr%0d_off%0d", it, off));
            end else begin
                off = int'($urandom_range(0, 7));
                rd(off, $sformatf("rand_rd%0d_off%0d", it, off));
            end
            settle($sformatf("rand%0d", it));
        end

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwpic2_wb.md
# fwpic2_wb

Second-generation Wishbone-attached programmable interrupt controller for up to 32 interrupt sources. Each channel has:
- a configurable synchroniser, polarity and edge/level mode;
- enable and write-1-to-clear pending registers.

A CLAIM register returns the lowest-index active source and atomically retires its edge pending bit. The block sits on the peripheral Wishbone bus and drives a single interrupt line plus source ID to the core.

## Interface
Parameters:
- N_IRQ, 8, number of interrupt sources, 1..32
- SYNC_STAGES, 2, irq synchroniser flops per channel, ≥1

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- rt_adr  in  32  byte address; only [4:2] decoded
- rt_dat_w  in  32  write data
- rt_dat_r  out  32  read data, valid while rt_ack=1
- rt_cyc, rt_stb, rt_we  in  1  Wishbone classic cycle controls
- rt_sel  in  4  byte-lane enables for writes
- rt_ack  out  1  transfer acknowledge
- int_o  out  1  interrupt request to core, registered
- int_id  out  8  lowest active source index, 0 when int_o=0
- irq  in  N_IRQ  asynchronous interrupt sources

## Operation
- Register map, word offsets on rt_adr[4:2]:
  - 0 STATUS RO = PENDING & ENABLE.
  - 1 PENDING: read; write 1 clears edge-mode bits.
  - 2 ENABLE RW.
  - 3 MODE RW, 1=rising edge, 0=level.
  - 4 POLARITY RW, 1=active-low.
  - 5 CLAIM RO = {valid[31], 23'b0, id[7:0]}.
  - 6 CTRL RW, bit0 = global enable.
  - 7 reads 0, writes ignored.
- Per-channel processing:
  - Polarity-corrected level s[i] = sync(irq[i]) ^ POLARITY[i].
  - Level mode: PENDING[i] tracks s[i] registered each cycle; W1C has no effect.
  - Edge mode: PENDING[i] sets on s[i] 0→1 and holds until W1C or claim.
- Register bits ≥ N_IRQ read 0 and ignore writes.
- RW and W1C writes honour rt_sel per byte lane.
- Active = STATUS != 0 && CTRL[0].
- CLAIM read returns the lowest index i with STATUS[i]=1, valid=1. If channel i is edge-mode, PENDING[i] clears on the same edge that asserts rt_ack. If nothing is active, it returns 0 with no side effect.
- Simultaneous events, set always wins:
  - new edge + W1C on the same bit → bit stays 1;
  - new edge + claim-clear on the same bit → bit stays 1.
- Writing MODE or POLARITY does not clear PENDING. A polarity flip may create an edge, and that edge sets pending.

## Timing
- Reset values:
  - rt_ack=0, rt_dat_r=0, int_o=0, int_id=0;
  - all registers 0; synchronisers 0; edge history 0.
- Ack FSM, two states:
  - IDLE→ACK when rt_cyc&&rt_stb.
  - ACK→IDLE unconditionally.
  - rt_ack is high for exactly 1 cycle, 1 cycle after the request is sampled.
  - A held strobe yields ack every other cycle.
- Write commit and rt_dat_r capture occur on the clock edge that sets rt_ack. Read data is the pre-write state.
- Latency from irq to PENDING: SYNC_STAGES+1 cycles.
- int_o/int_id register PENDING-derived state: int_o rises 1 cycle after STATUS becomes nonzero. Total irq→int_o latency is SYNC_STAGES+2.
- Claim clear is visible in int_o 1 cycle after ack.
- Reset asserted mid-transfer: ack drops immediately and the transfer is lost. The master must retry.
- Deasserting rt_cyc/rt_stb while in ACK: ack still completes its single cycle, and the write has already committed.

## Structure
- Package fwpic2_pkg holds:
  - register offset localparams (REG_STATUS..REG_CTRL);
  - MODE_LEVEL/MODE_EDGE constants;
  - CLAIM_VALID_BIT=31.
- Sub-module fwpic2_chan, one instance per channel via generate. It contains:
  - synchroniser, polarity XOR, edge detect;
  - pending flop with set-wins clear input.
- Top level holds:
  - Wishbone ack FSM and register file;
  - lowest-index priority encoder;
  - int_o/int_id output registers.

## Test plan
- **Reset and defaults:** reset then read all 8 offsets → all 0; int_o=0; each read acks in 1 cycle.
- **Level channel:**
  - Stimulus: ENABLE=0x04, CTRL=1, irq[2]=1.
  - Required: int_o=1 and int_id=2 after SYNC_STAGES+2 cycles.
  - Then W1C PENDING=0x04 → PENDING stays 0x04.
  - Then drop irq[2] → int_o=0.
- **Edge + claim:**
  - Stimulus: MODE=0x0A, ENABLE=0x0A, CTRL=1; pulse irq[1] and irq[3] for 1 cycle.
  - Required: CLAIM reads 0x80000001, then 0x80000003, then 0x00000000; int_o falls after the second claim.
- **Polarity + byte lanes:**
  - POLARITY=0x01 with irq[0]=0 → PENDING bit0=1.
  - Write ENABLE=0xFFFFFFFF with rt_sel=0001, N_IRQ=8 → ENABLE reads 0x000000FF.
- **Set-wins race:** in edge mode, align an irq[0] rising edge with the W1C ack edge → PENDING bit0 reads 1.
- **Global gate / mid-cycle reset:**
  - CTRL=0 with STATUS=0x01 → int_o=0.
  - Reset asserted during ACK → rt_ack=0 immediately, registers cleared.
